btn_mode_ctrl: RTL
==================

# btn_mode_ctrl

Mode-selection controller for the image-processing pipeline. It sits behind the per-button debouncers and turns their stable levels into a wrapped filter-mode index. Edge detection, fixed-priority arbitration of simultaneous presses, and long-press auto-repeat are handled here. Every mode change is delivered to the pipeline through a valid/ready handshake and takes effect only once the pipeline accepts it.

## Interface
- `NUM_MODES`, default 8: number of modes, ≥2. Mode index range is 0..NUM_MODES-1. `MODE_W = $clog2(NUM_MODES)` is a derived localparam.
- `HOLD_TICKS`, default 50_000_000: cycles a direction button must stay held after a commit before the first auto-repeat (0.5 s at 100 MHz). ≥2.
- `REPEAT_TICKS`, default 10_000_000: cycles between subsequent auto-repeats. ≥2.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_next` in 1: debounced level, step mode +1.
- `btn_prev` in 1: debounced level, step mode −1.
- `btn_home` in 1: debounced level, return to mode 0.
- `pipe_ready` in 1: pipeline can accept a new mode this cycle.
- `mode_req` out MODE_W: requested mode; valid while `mode_valid`=1.
- `mode_valid` out 1: request pending.
- `mode` out MODE_W: committed mode, changes only on handshake.
- `repeat_active` out 1: auto-repeat cadence engaged.
- `busy` out 1: state ≠ IDLE.

## Operation
- Rising-edge detect per button: registered previous level, reset 0. An edge is level=1 while prev=0.
- Edges are accepted only in IDLE. Edges in any other state are discarded; no queuing.
- Simultaneous edges are resolved by priority: home > next > prev. Losers are discarded.
- Arithmetic for next: NUM_MODES-1 wraps to 0, else +1. Arithmetic for prev: 0 wraps to NUM_MODES-1, else −1. Home always gives 0, even if `mode` is already 0; the request is still issued.
- A `dir` register latches which button (next/prev/home) started the sequence.
- FSM states:
  - IDLE → PUSH on an accepted edge. Same edge loads `mode_req` with the new value and clears `repeat_active`.
  - PUSH: `mode_valid`=1 and `mode_req` is held stable. On `mode_valid & pipe_ready`: `mode`←`mode_req`, `mode_valid`←0. Next state is HOLD if `dir`≠home and the `dir` button is still high, else IDLE.
  - HOLD: counter is cleared on entry and increments every HOLD cycle. Threshold is HOLD_TICKS when `repeat_active`=0, REPEAT_TICKS otherwise.
    - If the `dir` button goes low: → IDLE, `repeat_active`←0.
    - Else, at count == threshold−1: `mode_req`←step(`mode`), `repeat_active`←1, → PUSH.
- A button released during PUSH does not cancel the push. The commit completes, then the FSM goes to IDLE.
- Counter width is `$clog2(max(HOLD_TICKS,REPEAT_TICKS))+1`. It saturates and never wraps.

## Timing
- Reset values: `mode`=0, `mode_req`=0, `mode_valid`=0, `repeat_active`=0, `busy`=0, FSM=IDLE, counter=0, edge registers=0.
- Reset mid-operation aborts everything immediately, including a pending `mode_valid`. After reset release, a button already held produces an edge on the first clock.
- Edge sampled at cycle t → `mode_valid`=1 and `busy`=1 at t+1.
- With `pipe_ready`=1 at t+1, the handshake completes at t+1: `mode` is updated at t+2 and `mode_valid`=0 at t+2.
- `pipe_ready` low stalls PUSH indefinitely. `mode_req` must not change while stalled.
- First repeat: `mode_valid` rises exactly HOLD_TICKS cycles after HOLD entry. Later repeats rise REPEAT_TICKS cycles after each HOLD re-entry.
- Minimum spacing between commits (for a held button) = 1 + threshold cycles.

## Test plan
- Reset, then pulse `btn_next`, `pipe_ready`=1, NUM_MODES=4 → `mode_valid` for one cycle with `mode_req`=1; `mode`=1 two cycles after the edge. Four presses give 1,2,3,0 (wrap).
- From `mode`=0, press `btn_prev` → `mode_req`=3. Press `btn_next`+`btn_home` on the same cycle → only home is taken, `mode_req`=0. Press next+prev together → next wins.
- Hold `btn_next`, HOLD_TICKS=8, REPEAT_TICKS=4, `pipe_ready`=1 → commits at edge+2, then every 9 cycles once, then every 5 cycles. `repeat_active` rises with the first repeat. Release → IDLE, `repeat_active`=0.
- `pipe_ready`=0 for 20 cycles during PUSH, with extra `btn_prev` edges → `mode_req` stays stable, extra edges are dropped, and `mode` commits exactly once when `pipe_ready` rises.
- Assert `rst_n`=0 while `mode_valid`=1 with `mode`=2 → all outputs return to reset values asynchronously. After release, a held `btn_next` gives `mode_req`=1.

Source files
------------

// File: rtl/btn_mode_ctrl.sv
// Button-driven filter-mode controller: edge detect, priority arbitration,
// long-press auto-repeat, and valid/ready delivery of the new mode.
module btn_mode_ctrl #(
  parameter  int unsigned NUM_MODES    = 8,
  parameter  int unsigned HOLD_TICKS   = 50_000_000,
  parameter  int unsigned REPEAT_TICKS = 10_000_000,
  localparam int unsigned MODE_W       = $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_home,
  input  logic              pipe_ready,
  output logic [MODE_W-1:0] mode_req,
  output logic              mode_valid,
  output logic [MODE_W-1:0] mode,
  output logic              repeat_active,
  output logic              busy
);

  localparam int unsigned TICK_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned CNT_W    = $clog2(TICK_MAX) + 1;

  localparam logic [MODE_W-1:0] MODE_MAX    = MODE_W'(NUM_MODES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0]  REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    DIR_NEXT,
    DIR_PREV,
    DIR_HOME
  } dir_t;

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d;
  logic [2:0]         btn_q;
  logic [2:0]         btn_edge;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [MODE_W-1:0]  req_q, req_d;
  logic               valid_q, valid_d;
  logic               rep_q, rep_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_btn;

  function automatic logic [MODE_W-1:0] step(input logic [MODE_W-1:0] m, input dir_t d);
    logic [MODE_W-1:0] r;
    r = '0;
    case (d)
      DIR_NEXT: r = (m == MODE_MAX) ? '0 : m + MODE_W'(1);
      DIR_PREV: r = (m == '0) ? MODE_MAX : m - MODE_W'(1);
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Bit order {home, next, prev} matches arbitration priority.
  assign btn_edge = {btn_home, btn_next, btn_prev} & ~btn_q;

  always_comb begin
    dir_btn = 1'b0;
    case (dir_q)
      DIR_NEXT: dir_btn = btn_next;
      DIR_PREV: dir_btn = btn_prev;
      default:  dir_btn = btn_home;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    req_d   = req_q;
    valid_d = valid_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_edge != 3'b000) begin
          if (btn_edge[2])      dir_d = DIR_HOME;
          else if (btn_edge[1]) dir_d = DIR_NEXT;
          else                  dir_d = DIR_PREV;
          req_d   = step(mode_q, dir_d);
          valid_d = 1'b1;
          rep_d   = 1'b0;
          state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (valid_q && pipe_ready) begin
          mode_d  = req_q;
          valid_d = 1'b0;
          if (dir_q != DIR_HOME && dir_btn) begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (!dir_btn) begin
          rep_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == (rep_q ? REPEAT_LAST : HOLD_LAST)) begin
          req_d   = step(mode_q, dir_q);
          valid_d = 1'b1;
          rep_d   = 1'b1;
          state_d = ST_PUSH;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NEXT;
      btn_q   <= '0;
      mode_q  <= '0;
      req_q   <= '0;
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      btn_q   <= {btn_home, btn_next, btn_prev};
      mode_q  <= mode_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mode_req      = req_q;
  assign mode_valid    = valid_q;
  assign mode          = mode_q;
  assign repeat_active = rep_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
